// File: rtl/rv32i_types.sv
// Shared types for the snoop bus adapters.
// Bus commands, bus responses and adapter FSM states.
package rv32i_types;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   typedef enum logic [2:0] {
      BUS_NONE   = 3'd0,
      BUS_BUSRD  = 3'd1,
      BUS_BUSRDX = 3'd2,
      BUS_UPGR   = 3'd3,
      BUS_FLUSH  = 3'd4
   } bus_cmd_t;

   typedef enum logic [1:0] {
      BUS_RESP_NONE = 2'd0,
      BUS_RESP_HIT  = 2'd1,
      BUS_RESP_MISS = 2'd2
   } bus_resp_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARB  = 3'd1,
      S_CMD  = 3'd2,
      S_RESP = 3'd3,
      S_DONE = 3'd4
   } adapter_state_t;

endpackage

// File: rtl/snoop_bus_adapter.sv
// Per-cache bridge to the shared snoop bus.
// Issues one held request at a time and forwards peer snoops.
module snoop_bus_adapter #(
   parameter bit HIGH_PRIO = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cache_req_valid,
   input  logic [31:0]  cache_req_addr,
   input  logic [2:0]   cache_req_cmd,
   input  logic [255:0] cache_req_data,
   output logic         cache_req_ready,
   output logic         cache_resp_valid,
   output logic         cache_resp_hit,
   output logic [255:0] cache_resp_data,
   output logic         snoop_valid,
   output logic [31:0]  snoop_addr,
   output logic [2:0]   snoop_cmd,
   input  logic         snoop_hit,
   input  logic [255:0] snoop_data,
   output logic         bus_query,
   output logic [31:0]  bus_addr,
   output logic [2:0]   bus_command,
   output logic [255:0] bus_data,
   input  logic         peer_bus_query,
   input  logic         bus_ready,
   input  logic [31:0]  bus_command_address,
   input  logic [2:0]   bus_command_command,
   input  logic [1:0]   bus_resp,
   input  logic [255:0] bus_resp_data,
   output logic         bus_snoop_hit,
   output logic [255:0] bus_snoop_data
);
   import rv32i_types::*;

   adapter_state_t      state;
   logic [ADDR_W-1:0]   hold_addr;
   logic [2:0]          hold_cmd;
   logic [LINE_W-1:0]   hold_data;
   logic                resp_hit;
   logic [LINE_W-1:0]   resp_data;
   logic                bus_ready_q;
   logic                grant;
   logic                hold_active;
   logic                snoop_cyc;

   assign grant = bus_ready && (HIGH_PRIO || !peer_bus_query);

   // Requester FSM: accept, arbitrate, hold command, capture result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         hold_addr <= '0;
         hold_cmd  <= '0;
         hold_data <= '0;
         resp_hit  <= 1'b0;
         resp_data <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (cache_req_valid && cache_req_cmd != BUS_NONE) begin
                  hold_addr <= cache_req_addr;
                  hold_cmd  <= cache_req_cmd;
                  hold_data <= cache_req_data;
                  state     <= S_ARB;
               end
            end
            S_ARB: begin
               if (grant) state <= S_CMD;
            end
            S_CMD: begin
               state <= S_RESP;
            end
            S_RESP: begin
               resp_hit  <= (bus_resp == BUS_RESP_HIT);
               resp_data <= bus_resp_data;
               state     <= S_DONE;
            end
            S_DONE: begin
               resp_hit  <= 1'b0;
               resp_data <= '0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign hold_active = (state == S_ARB) || (state == S_CMD)
                     || (state == S_RESP);

   assign cache_req_ready  = (state == S_IDLE);
   assign cache_resp_valid = (state == S_DONE);
   assign cache_resp_hit   = resp_hit;
   assign cache_resp_data  = resp_data;

   assign bus_query   = (state == S_ARB);
   assign bus_addr    = hold_active ? hold_addr : '0;
   assign bus_command = hold_active ? hold_cmd  : '0;
   assign bus_data    = hold_active ? hold_data : '0;

   // Our own broadcast happens in CMD and must not snoop our cache.
   assign snoop_cyc = bus_ready_q
                   && (bus_command_command != BUS_NONE)
                   && (state != S_CMD);

   assign snoop_valid = snoop_cyc;
   assign snoop_addr  = snoop_cyc ? bus_command_address : '0;
   assign snoop_cmd   = snoop_cyc ? bus_command_command : '0;

   // Snoop capture: hold the cache answer for the bus response cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_ready_q    <= 1'b0;
         bus_snoop_hit  <= 1'b0;
         bus_snoop_data <= '0;
      end else begin
         bus_ready_q    <= bus_ready;
         bus_snoop_hit  <= snoop_cyc && snoop_hit;
         bus_snoop_data <= snoop_cyc ? snoop_data : '0;
      end
   end

endmodule

// File: tb/tb_snoop_bus_adapter.sv
// Scoreboard bench for a pair of snoop bus adapters.
// Low and high priority instances share one bus model.
module tb_snoop_bus_adapter;

   typedef struct {
      logic         hit;
      logic [255:0] data;
      int           cyc;
   } exp_t;

   localparam logic [255:0] D1 = {8{32'h1111_0001}};
   localparam logic [255:0] D2 = {8{32'h2222_0002}};
   localparam logic [255:0] D3 = {8{32'h3333_0003}};
   localparam logic [255:0] D4 = {8{32'h4444_0004}};
   localparam logic [255:0] D5 = {8{32'h5555_0005}};
   localparam logic [255:0] D6 = {8{32'h6666_0006}};
   localparam logic [255:0] R1 = {8{32'hA1A1_0101}};
   localparam logic [255:0] R2 = {8{32'hB2B2_0202}};
   localparam logic [255:0] R3 = {8{32'hC3C3_0303}};
   localparam logic [255:0] RA = {8{32'hDADA_0A0A}};
   localparam logic [255:0] RB = {8{32'hEBEB_0B0B}};
   localparam logic [255:0] AB = {32{8'hAB}};

   logic         clk = 1'b0;
   logic         rst;
   int           cyc_n = 0;
   int           total = 0;
   int           bad = 0;
   int           c0;
   exp_t         lo_q[$];
   exp_t         hi_q[$];

   logic         bus_ready;
   logic [31:0]  bus_command_address;
   logic [2:0]   bus_command_command;
   logic [1:0]   bus_resp;
   logic [255:0] bus_resp_data;

   logic         lo_req_valid, hi_req_valid;
   logic [31:0]  lo_req_addr, hi_req_addr;
   logic [2:0]   lo_req_cmd, hi_req_cmd;
   logic [255:0] lo_req_data, hi_req_data;
   logic         lo_req_ready, hi_req_ready;
   logic         lo_resp_valid, hi_resp_valid;
   logic         lo_resp_hit, hi_resp_hit;
   logic [255:0] lo_resp_data, hi_resp_data;
   logic         lo_snoop_valid, hi_snoop_valid;
   logic [31:0]  lo_snoop_addr, hi_snoop_addr;
   logic [2:0]   lo_snoop_cmd, hi_snoop_cmd;
   logic         lo_snoop_hit, hi_snoop_hit;
   logic [255:0] lo_snoop_data, hi_snoop_data;
   logic         lo_bus_query, hi_bus_query;
   logic [31:0]  lo_bus_addr, hi_bus_addr;
   logic [2:0]   lo_bus_command, hi_bus_command;
   logic [255:0] lo_bus_data, hi_bus_data;
   logic         lo_bs_hit, hi_bs_hit;
   logic [255:0] lo_bs_data, hi_bs_data;

   always #5 clk = ~clk;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   snoop_bus_adapter #(.HIGH_PRIO(1'b0)) u_lo (
      .clk(clk), .rst(rst),
      .cache_req_valid(lo_req_valid), .cache_req_addr(lo_req_addr),
      .cache_req_cmd(lo_req_cmd), .cache_req_data(lo_req_data),
      .cache_req_ready(lo_req_ready), .cache_resp_valid(lo_resp_valid),
      .cache_resp_hit(lo_resp_hit), .cache_resp_data(lo_resp_data),
      .snoop_valid(lo_snoop_valid), .snoop_addr(lo_snoop_addr),
      .snoop_cmd(lo_snoop_cmd), .snoop_hit(lo_snoop_hit),
      .snoop_data(lo_snoop_data), .bus_query(lo_bus_query),
      .bus_addr(lo_bus_addr), .bus_command(lo_bus_command),
      .bus_data(lo_bus_data), .peer_bus_query(hi_bus_query),
      .bus_ready(bus_ready), .bus_command_address(bus_command_address),
      .bus_command_command(bus_command_command), .bus_resp(bus_resp),
      .bus_resp_data(bus_resp_data), .bus_snoop_hit(lo_bs_hit),
      .bus_snoop_data(lo_bs_data)
   );

   snoop_bus_adapter #(.HIGH_PRIO(1'b1)) u_hi (
      .clk(clk), .rst(rst),
      .cache_req_valid(hi_req_valid), .cache_req_addr(hi_req_addr),
      .cache_req_cmd(hi_req_cmd), .cache_req_data(hi_req_data),
      .cache_req_ready(hi_req_ready), .cache_resp_valid(hi_resp_valid),
      .cache_resp_hit(hi_resp_hit), .cache_resp_data(hi_resp_data),
      .snoop_valid(hi_snoop_valid), .snoop_addr(hi_snoop_addr),
      .snoop_cmd(hi_snoop_cmd), .snoop_hit(hi_snoop_hit),
      .snoop_data(hi_snoop_data), .bus_query(hi_bus_query),
      .bus_addr(hi_bus_addr), .bus_command(hi_bus_command),
      .bus_data(hi_bus_data), .peer_bus_query(lo_bus_query),
      .bus_ready(bus_ready), .bus_command_address(bus_command_address),
      .bus_command_command(bus_command_command), .bus_resp(bus_resp),
      .bus_resp_data(bus_resp_data), .bus_snoop_hit(hi_bs_hit),
      .bus_snoop_data(hi_bs_data)
   );

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every response pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && lo_resp_valid) begin
         if (lo_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL lo_unexpected_resp got=1 want=0");
         end else begin
            e = lo_q.pop_front();
            chk("lo_resp_hit", 256'(lo_resp_hit), 256'(e.hit));
            chk("lo_resp_data", lo_resp_data, e.data);
            chk("lo_resp_cycle", 256'(cyc_n), 256'(e.cyc));
         end
      end
      if (!rst && hi_resp_valid) begin
         if (hi_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL hi_unexpected_resp got=1 want=0");
         end else begin
            e = hi_q.pop_front();
            chk("hi_resp_hit", 256'(hi_resp_hit), 256'(e.hit));
            chk("hi_resp_data", hi_resp_data, e.data);
            chk("hi_resp_cycle", 256'(cyc_n), 256'(e.cyc));
         end
      end
   end

   initial begin
      rst = 1'b1;
      bus_ready = 1'b0;
      bus_command_address = '0;
      bus_command_command = '0;
      bus_resp = '0;
      bus_resp_data = '0;
      lo_req_valid = 1'b0; lo_req_addr = '0;
      lo_req_cmd = '0;     lo_req_data = '0;
      hi_req_valid = 1'b0; hi_req_addr = '0;
      hi_req_cmd = '0;     hi_req_data = '0;
      lo_snoop_hit = 1'b0; lo_snoop_data = '0;
      hi_snoop_hit = 1'b0; hi_snoop_data = '0;

      // reset state
      nxt(); nxt(); #2;
      chk("rst_lo_ready", 256'(lo_req_ready), 256'(1));
      chk("rst_hi_ready", 256'(hi_req_ready), 256'(1));
      chk("rst_lo_query", 256'(lo_bus_query), 256'(0));
      chk("rst_lo_respv", 256'(lo_resp_valid), 256'(0));
      chk("rst_lo_addr", 256'(lo_bus_addr), 256'(0));
      chk("rst_lo_bshit", 256'(lo_bs_hit), 256'(0));
      chk("rst_lo_snpv", 256'(lo_snoop_valid), 256'(0));
      nxt(); rst = 1'b0; bus_ready = 1'b1;
      nxt();

      // free bus, single BUSRD, miss
      nxt();
      lo_req_valid = 1'b1; lo_req_addr = 32'h0000_1040;
      lo_req_cmd = 3'd1;   lo_req_data = D1;
      c0 = cyc_n;
      lo_q.push_back('{hit: 1'b0, data: R1, cyc: c0 + 4});
      #2;
      chk("t2_c0_ready", 256'(lo_req_ready), 256'(1));
      chk("t2_c0_query", 256'(lo_bus_query), 256'(0));
      nxt(); lo_req_valid = 1'b0; #2;
      chk("t2_c1_query", 256'(lo_bus_query), 256'(1));
      chk("t2_c1_addr", 256'(lo_bus_addr), 256'(32'h1040));
      chk("t2_c1_cmd", 256'(lo_bus_command), 256'(1));
      chk("t2_c1_data", lo_bus_data, D1);
      chk("t2_c1_ready", 256'(lo_req_ready), 256'(0));
      nxt();
      bus_command_command = 3'd1; bus_command_address = 32'h1040;
      #2;
      chk("t2_c2_query", 256'(lo_bus_query), 256'(0));
      chk("t2_own_snpv", 256'(lo_snoop_valid), 256'(0));
      chk("t2_peer_snpv", 256'(hi_snoop_valid), 256'(1));
      chk("t2_peer_snpa", 256'(hi_snoop_addr), 256'(32'h1040));
      chk("t2_c2_addr", 256'(lo_bus_addr), 256'(32'h1040));
      nxt();
      bus_command_command = '0; bus_command_address = '0;
      bus_resp = 2'd2; bus_resp_data = R1;
      #2;
      chk("t2_c3_query", 256'(lo_bus_query), 256'(0));
      chk("t2_c3_cmd", 256'(lo_bus_command), 256'(1));
      nxt(); bus_resp = '0; bus_resp_data = '0; #2;
      chk("t2_c4_addr", 256'(lo_bus_addr), 256'(0));
      chk("t2_c4_ready", 256'(lo_req_ready), 256'(0));
      nxt(); #2;
      chk("t2_c5_ready", 256'(lo_req_ready), 256'(1));

      // contention: high priority wins, low waits for bus
      nxt();
      lo_req_valid = 1'b1; lo_req_addr = 32'h0000_1100;
      lo_req_cmd = 3'd1;   lo_req_data = D2;
      hi_req_valid = 1'b1; hi_req_addr = 32'h0000_1200;
      hi_req_cmd = 3'd2;   hi_req_data = D3;
      c0 = cyc_n;
      hi_q.push_back('{hit: 1'b1, data: R2, cyc: c0 + 4});
      lo_q.push_back('{hit: 1'b1, data: R3, cyc: c0 + 8});
      nxt(); lo_req_valid = 1'b0; hi_req_valid = 1'b0; #2;
      chk("t3_c1_loq", 256'(lo_bus_query), 256'(1));
      chk("t3_c1_hiq", 256'(hi_bus_query), 256'(1));
      nxt(); bus_ready = 1'b0; #2;
      chk("t3_c2_hiq", 256'(hi_bus_query), 256'(0));
      chk("t3_c2_loq", 256'(lo_bus_query), 256'(1));
      chk("t3_c2_hiaddr", 256'(hi_bus_addr), 256'(32'h1200));
      nxt(); bus_resp = 2'd1; bus_resp_data = R2; #2;
      chk("t3_c3_loq", 256'(lo_bus_query), 256'(1));
      chk("t3_c3_loaddr", 256'(lo_bus_addr), 256'(32'h1100));
      nxt(); bus_resp = '0; bus_resp_data = '0; #2;
      chk("t3_c4_loq", 256'(lo_bus_query), 256'(1));
      nxt(); bus_ready = 1'b1; #2;
      chk("t3_c5_loq", 256'(lo_bus_query), 256'(1));
      chk("t3_c5_lodata", lo_bus_data, D2);
      nxt(); #2;
      chk("t3_c6_loq", 256'(lo_bus_query), 256'(0));
      chk("t3_c6_locmd", 256'(lo_bus_command), 256'(1));
      nxt(); bus_resp = 2'd1; bus_resp_data = R3;
      nxt(); bus_resp = '0; bus_resp_data = '0;
      nxt();

      // peer snoop BUSRDX with own hit
      nxt();
      bus_command_command = 3'd2; bus_command_address = 32'h2000;
      lo_snoop_hit = 1'b1; lo_snoop_data = AB;
      #2;
      chk("t4_snpv", 256'(lo_snoop_valid), 256'(1));
      chk("t4_snpa", 256'(lo_snoop_addr), 256'(32'h2000));
      chk("t4_snpc", 256'(lo_snoop_cmd), 256'(2));
      chk("t4_bsh_pre", 256'(lo_bs_hit), 256'(0));
      nxt();
      bus_command_command = '0; bus_command_address = '0;
      lo_snoop_hit = 1'b0; lo_snoop_data = '0;
      #2;
      chk("t4_snpv_off", 256'(lo_snoop_valid), 256'(0));
      chk("t4_snpa_off", 256'(lo_snoop_addr), 256'(0));
      chk("t4_bsh", 256'(lo_bs_hit), 256'(1));
      chk("t4_bsd", lo_bs_data, AB);
      nxt(); #2;
      chk("t4_bsh_clr", 256'(lo_bs_hit), 256'(0));
      chk("t4_bsd_clr", lo_bs_data, 256'(0));
      nxt(); bus_ready = 1'b0;
      nxt();
      bus_ready = 1'b1;
      bus_command_command = 3'd1; bus_command_address = 32'h2040;
      lo_snoop_hit = 1'b1;
      #2;
      chk("t4_rdyq_gate", 256'(lo_snoop_valid), 256'(0));
      nxt(); #2;
      chk("t4_rdyq_snpv", 256'(lo_snoop_valid), 256'(1));
      chk("t4_gate_bsh", 256'(lo_bs_hit), 256'(0));
      nxt();
      bus_command_command = '0; bus_command_address = '0;
      lo_snoop_hit = 1'b0;
      #2;
      chk("t4_rdyq_bsh", 256'(lo_bs_hit), 256'(1));
      nxt();

      // reset during RESP drops the transaction
      nxt();
      lo_req_valid = 1'b1; lo_req_addr = 32'h0000_1800;
      lo_req_cmd = 3'd4;   lo_req_data = D6;
      nxt(); lo_req_valid = 1'b0;
      nxt();
      nxt(); bus_resp = 2'd1; bus_resp_data = R1; rst = 1'b1; #2;
      chk("t5_resp_addr", 256'(lo_bus_addr), 256'(32'h1800));
      nxt(); rst = 1'b0; bus_resp = '0; bus_resp_data = '0; #2;
      chk("t5_ready", 256'(lo_req_ready), 256'(1));
      chk("t5_respv", 256'(lo_resp_valid), 256'(0));
      chk("t5_query", 256'(lo_bus_query), 256'(0));
      chk("t5_addr", 256'(lo_bus_addr), 256'(0));
      chk("t5_rhit", 256'(lo_resp_hit), 256'(0));
      chk("t5_rdata", lo_resp_data, 256'(0));
      nxt(); #2;
      chk("t5_respv2", 256'(lo_resp_valid), 256'(0));
      nxt();

      // back-to-back requests
      nxt();
      lo_req_valid = 1'b1; lo_req_addr = 32'h0000_3000;
      lo_req_cmd = 3'd2;   lo_req_data = D4;
      c0 = cyc_n;
      lo_q.push_back('{hit: 1'b0, data: RA, cyc: c0 + 4});
      lo_q.push_back('{hit: 1'b1, data: RB, cyc: c0 + 9});
      nxt();
      lo_req_addr = 32'h0000_3040; lo_req_cmd = 3'd3; lo_req_data = D5;
      #2;
      chk("t6_c1_addr", 256'(lo_bus_addr), 256'(32'h3000));
      chk("t6_c1_ready", 256'(lo_req_ready), 256'(0));
      nxt();
      nxt(); bus_resp = 2'd2; bus_resp_data = RA; #2;
      chk("t6_c3_data", lo_bus_data, D4);
      nxt(); bus_resp = '0; bus_resp_data = '0; #2;
      chk("t6_c4_ready", 256'(lo_req_ready), 256'(0));
      nxt(); #2;
      chk("t6_c5_ready", 256'(lo_req_ready), 256'(1));
      nxt(); lo_req_valid = 1'b0; #2;
      chk("t6_c6_query", 256'(lo_bus_query), 256'(1));
      chk("t6_c6_addr", 256'(lo_bus_addr), 256'(32'h3040));
      chk("t6_c6_data", lo_bus_data, D5);
      chk("t6_c6_cmd", 256'(lo_bus_command), 256'(3));
      nxt();
      nxt(); bus_resp = 2'd1; bus_resp_data = RB;
      nxt(); bus_resp = '0; bus_resp_data = '0;
      nxt();

      // BUS_NONE request is ignored
      nxt();
      lo_req_valid = 1'b1; lo_req_addr = 32'h0000_4000;
      lo_req_cmd = 3'd0;   lo_req_data = D1;
      nxt(); lo_req_valid = 1'b0; #2;
      chk("t7_ready", 256'(lo_req_ready), 256'(1));
      chk("t7_query", 256'(lo_bus_query), 256'(0));
      chk("t7_addr", 256'(lo_bus_addr), 256'(0));

      nxt(); nxt(); nxt(); #2;
      chk("lo_q_drained", 256'(lo_q.size()), 256'(0));
      chk("hi_q_drained", 256'(hi_q.size()), 256'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/snoop_bus_adapter.md
# snoop_bus_adapter

Per-cache bridge between one L1 data cache (ooo or ppl core) and the shared snoop bus arbiter. It accepts a single coherence request from its cache, arbitrates for the bus, holds the command stable for the bus's two-cycle transaction and returns the hit/miss result and peer data to the cache. In the other direction it forwards the peer's bus commands to its own cache as one-cycle snoops, registering the cache's answer so the bus sees a stable hit flag and line during its response cycle. Two instances exist: one per core, with `HIGH_PRIO=1` on the ooo side.

## Interface
- `HIGH_PRIO`, default 0: 1 means this side wins when both adapters query in the same cycle.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `cache_req_valid` in 1: cache has a request.
- `cache_req_addr` in 32: line address.
- `cache_req_cmd` in 3: `bus_cmd_t`.
- `cache_req_data` in 256: writeback line.
- `cache_req_ready` out 1: request accepted this cycle.
- `cache_resp_valid` out 1: one-cycle result pulse.
- `cache_resp_hit` out 1: the peer held the line.
- `cache_resp_data` out 256: peer line.
- `snoop_valid` out 1: snoop lookup strobe to own cache.
- `snoop_addr` out 32: snooped address.
- `snoop_cmd` out 3: snooped command.
- `snoop_hit` in 1: own cache hit, same cycle as `snoop_valid`.
- `snoop_data` in 256: own line, same cycle as `snoop_valid`.
- `bus_query` out 1: request for the bus.
- `bus_addr` out 32: held command address.
- `bus_command` out 3: held command.
- `bus_data` out 256: held command data.
- `peer_bus_query` in 1: other adapter's `bus_query`.
- `bus_ready` in 1: bus is free.
- `bus_command_address` in 32: broadcast address.
- `bus_command_command` in 3: broadcast command.
- `bus_resp` in 2: 0 none, 1 hit, 2 miss.
- `bus_resp_data` in 256: response line.
- `bus_snoop_hit` out 1: registered snoop hit, to the bus.
- `bus_snoop_data` out 256: registered snoop line, to the bus.

## Operation
- The requester FSM has five states: IDLE, ARB, CMD, RESP and DONE.
- IDLE:
  - `cache_req_ready`=1.
  - On `cache_req_valid`, latch addr, cmd and data into the hold registers and go to ARB.
- ARB:
  - `bus_query`=1.
  - Granted when `bus_ready` && (`HIGH_PRIO` || !`peer_bus_query`); then go to CMD, otherwise stay.
- CMD: the bus is broadcasting our command. Go to RESP.
- RESP:
  - Latch `cache_resp_hit` = (`bus_resp`==1) and `cache_resp_data` = `bus_resp_data`.
  - Go to DONE.
- DONE: `cache_resp_valid`=1 for exactly one cycle, then go to IDLE.
- `bus_query` is asserted only in ARB. It drops in the cycle after the grant, so the bus never re-arbitrates the same request.
- `bus_addr`, `bus_command` and `bus_data` are driven from the hold registers in ARB, CMD and RESP, and are 0 otherwise.
- The snoop side runs independently of the requester FSM.
- `bus_ready_q` is `bus_ready` registered.
- A snoop cycle is `bus_ready_q` && `bus_command_command` != BUS_NONE && state != CMD. This excludes our own broadcast.
- In a snoop cycle:
  - `snoop_valid`=1.
  - `snoop_addr` = `bus_command_address`.
  - `snoop_cmd` = `bus_command_command`.
  - At the clock edge, register `snoop_hit` and `snoop_data` into `bus_snoop_hit` and `bus_snoop_data`.
- Outside a snoop cycle, `snoop_valid`=0 and `snoop_addr`/`snoop_cmd` are 0.
- `bus_snoop_hit` and `bus_snoop_data` are valid during the cycle after a snoop cycle (the bus response cycle) and are cleared to 0 in every other cycle.
- A request and a snoop can be in flight together, because the adapter can sit in ARB while the peer owns the bus.
- `cache_req_cmd` = BUS_NONE is illegal and is ignored: the adapter stays in IDLE.

## Timing
- Reset values:
  - State = IDLE.
  - All outputs 0, except `cache_req_ready`, which is 1 in IDLE.
  - Hold registers, response registers and `bus_ready_q` are 0.
- Minimum latency with the bus free and no contention:
  - Accept at cycle 0.
  - `bus_query` at cycle 1.
  - CMD at cycle 2.
  - RESP at cycle 3.
  - `cache_resp_valid` at cycle 4.
- Under contention, a low-priority adapter stays in ARB with its request held until it is granted.
- The next request can be accepted in the cycle after DONE.
- Reset mid-transaction returns the FSM to IDLE on the next edge. The in-flight result is dropped and no `cache_resp_valid` is issued.

## Structure
- `rv32i_types` gets:
  - `bus_cmd_t` (3b): NONE=0, BUSRD=1, BUSRDX=2, UPGR=3, FLUSH=4.
  - `bus_resp_t` (2b): NONE=0, HIT=1, MISS=2.
  - An adapter state enum.
- No sub-module. The snoop capture stays inline as one registered process.

## Test plan
- Free bus, request addr 0x0000_1040 BUSRD, `bus_resp`=2 in RESP -> `bus_query` at cycle 1 only, `cache_resp_valid` at cycle 4 with hit=0.
- Both adapters request in the same cycle -> the HIGH_PRIO=1 side gets CMD at cycle 2; the HIGH_PRIO=0 side holds `bus_query` until the bus frees, then is granted.
- Peer broadcasts BUSRDX at 0x0000_2000 after bus free -> `snoop_valid` for one cycle with cmd=2. With `snoop_hit`=1 and data 0xAB…AB, the next cycle shows `bus_snoop_hit`=1 and that data, then 0.
- Own broadcast (state CMD) -> `snoop_valid` stays 0.
- `rst` asserted during RESP -> next cycle state IDLE, all outputs 0, `cache_req_ready`=1, no `cache_resp_valid`.
- Back-to-back requests -> the second is accepted in the cycle after DONE, and its hold data differs from the first.
